// File: rtl/stack_exec_unit.sv
// -----------------------------------------------------------------------------
// stack_exec_unit
//   Operand-stack execution unit for the stack-machine processor. Top-of-stack
//   lives in a register; the remaining entries live in mem[0..DEPTH-2], with
//   next-on-stack at mem[count-2]. Commands arrive over a valid/ready
//   handshake. Unary commands complete in one cycle. ADD/SUB/AND spend one
//   extra EXEC cycle with cmd_ready low.
//
//   Optional feature macro: STACK_ERR_STICKY_EN
//     defined   : an illegal command latches err and blocks cmd_ready until rst
//     undefined : err is a one-cycle pulse, and the illegal command is dropped
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only in IDLE
//   cmd_op            0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 NOT, 7 DUP
//   cmd_data          PUSH operand
//   tos, count        top of stack (0 when empty), number of valid entries
//   empty, full, zero stack status for controller branch decisions
//   done              one-cycle pulse when an accepted command completes
//   err               illegal command indication
// -----------------------------------------------------------------------------
module stack_exec_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] tos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             zero,
   output logic             done,
   output logic             err
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

`ifdef STACK_ERR_STICKY_EN
   localparam bit ERR_STICKY = 1'b1;
`else
   localparam bit ERR_STICKY = 1'b0;
`endif

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_ADD  = 3'd3,
      OP_SUB  = 3'd4,
      OP_AND  = 3'd5,
      OP_NOT  = 3'd6,
      OP_DUP  = 3'd7
   } op_t;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state;
   op_t              op_q;
   op_t              op_in;
   logic [WIDTH-1:0] tos_r;
   logic [WIDTH-1:0] opb;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH-1];

   logic [CW-1:0]    cnt_m1, cnt_m2;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic [WIDTH-1:0] nos;
   logic             is_empty, is_full, accept, legal, mem_we;

   assign op_in    = op_t'(cmd_op);
   assign cnt_m1   = cnt - CW'(1);
   assign cnt_m2   = cnt - CW'(2);
   assign wr_addr  = cnt_m1[AW-1:0];
   assign rd_addr  = cnt_m2[AW-1:0];
   // Only consumed when count >= 2, so the address is always in range then.
   assign nos      = mem[rd_addr];
   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CW'(DEPTH));
   assign accept   = cmd_valid && cmd_ready;

   always_comb begin
      legal = 1'b1;
      case (op_in)
         OP_PUSH:               legal = !is_full;
         OP_POP, OP_NOT:        legal = !is_empty;
         OP_DUP:                legal = !is_empty && !is_full;
         OP_ADD, OP_SUB, OP_AND: legal = (cnt >= CW'(2));
         default:               legal = 1'b1;
      endcase
   end

   // The old TOS spills into mem[count-1] on PUSH (non-empty) and DUP.
   assign mem_we = accept && legal && !rst &&
                   ((op_in == OP_PUSH && !is_empty) || op_in == OP_DUP);

   // Stack storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr] <= tos_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= OP_NOP;
         tos_r <= '0;
         opb   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!ERR_STICKY) err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!legal) begin
                     err <= 1'b1;
                  end else begin
                     case (op_in)
                        OP_PUSH: begin
                           tos_r <= cmd_data;
                           cnt   <= cnt + CW'(1);
                           done  <= 1'b1;
                        end
                        OP_POP: begin
                           tos_r <= (cnt == CW'(1)) ? '0 : nos;
                           cnt   <= cnt_m1;
                           done  <= 1'b1;
                        end
                        OP_NOT: begin
                           tos_r <= ~tos_r;
                           done  <= 1'b1;
                        end
                        OP_DUP: begin
                           cnt  <= cnt + CW'(1);
                           done <= 1'b1;
                        end
                        OP_NOP: done <= 1'b1;
                        default: begin
                           // Binary op: capture NOS now, combine with TOS in EXEC.
                           opb   <= nos;
                           op_q  <= op_in;
                           state <= EXEC;
                        end
                     endcase
                  end
               end
            end
            EXEC: begin
               case (op_q)
                  OP_ADD:  tos_r <= opb + tos_r;
                  OP_SUB:  tos_r <= opb - tos_r;
                  default: tos_r <= opb & tos_r;
               endcase
               cnt   <= cnt_m1;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE) && !(ERR_STICKY && err);
   assign tos       = tos_r;
   assign count     = cnt;
   assign empty     = is_empty;
   assign full      = is_full;
   assign zero      = !is_empty && (tos_r == '0);

endmodule

// File: tb/tb_stack_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_exec_unit
//   Directed bench for stack_exec_unit (default build, WIDTH=8, DEPTH=16).
//   Inputs change 1 ns after the rising edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_stack_exec_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                          SUB = 3'd4, AND = 3'd5, NOT = 3'd6, DUP = 3'd7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'd0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [WIDTH-1:0] tos;
   logic [CW-1:0]    count;
   logic             empty, full, zero, done, err;

   int checks = 0;
   int errors = 0;

   stack_exec_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .count(count),
      .empty(empty), .full(full), .zero(zero), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one command for exactly one rising edge; returns 1 ns after it.
   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data);
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #1;
      // Reset state
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_tos",   32'(tos),   32'd0);
      check("rst_full",  32'(full),  32'd0);
      check("rst_zero",  32'(zero),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_err",   32'(err),   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: PUSH 5, PUSH 3, SUB -> 2
      send(PUSH, 8'd5);
      check("t1_push_done", 32'(done), 32'd1);
      send(PUSH, 8'd3);
      check("t1_push2_done", 32'(done), 32'd1);
      check("t1_count2", 32'(count), 32'd2);
      send(SUB, 8'd0);
      check("t1_exec_ready", 32'(cmd_ready), 32'd0);
      check("t1_exec_done",  32'(done),      32'd0);
      @(posedge clk); #1;
      check("t1_sub_ready", 32'(cmd_ready), 32'd1);
      check("t1_sub_done",  32'(done),      32'd1);
      check("t1_sub_tos",   32'(tos),       32'd2);
      check("t1_sub_count", 32'(count),     32'd1);
      @(posedge clk); #1;
      check("t1_done_once", 32'(done), 32'd0);

      // 2: wrap-around add, then subtract to zero
      do_reset();
      send(PUSH, 8'hF0);
      send(PUSH, 8'h20);
      send(ADD, 8'd0);
      @(posedge clk); #1;
      check("t2_add_tos",  32'(tos),   32'h10);
      check("t2_add_zero", 32'(zero),  32'd0);
      check("t2_add_cnt",  32'(count), 32'd1);
      send(PUSH, 8'h10);
      send(SUB, 8'd0);
      @(posedge clk); #1;
      check("t2_sub_tos",  32'(tos),   32'd0);
      check("t2_sub_zero", 32'(zero),  32'd1);
      check("t2_sub_cnt",  32'(count), 32'd1);

      // 3: fill, overflow, drain
      do_reset();
      for (int i = 1; i <= DEPTH; i++) send(PUSH, WIDTH'(i));
      check("t3_full",  32'(full),  32'd1);
      check("t3_count", 32'(count), 32'(DEPTH));
      check("t3_tos",   32'(tos),   32'(DEPTH));
      send(PUSH, 8'd99);
      check("t3_ovf_err",   32'(err),       32'd1);
      check("t3_ovf_done",  32'(done),      32'd0);
      check("t3_ovf_tos",   32'(tos),       32'(DEPTH));
      check("t3_ovf_cnt",   32'(count),     32'(DEPTH));
      check("t3_ovf_ready", 32'(cmd_ready), 32'd1);
      for (int i = DEPTH; i >= 1; i--) begin
         check("t3_pop_val", 32'(tos), 32'(i));
         send(POP, 8'd0);
         check("t3_pop_done", 32'(done), 32'd1);
      end
      check("t3_empty",     32'(empty), 32'd1);
      check("t3_empty_tos", 32'(tos),   32'd0);
      check("t3_empty_cnt", 32'(count), 32'd0);

      // 4: underflow on empty stack
      send(POP, 8'd0);
      check("t4_pop_err",  32'(err),   32'd1);
      check("t4_pop_done", 32'(done),  32'd0);
      check("t4_pop_cnt",  32'(count), 32'd0);
      send(ADD, 8'd0);
      check("t4_add_err",   32'(err),       32'd1);
      check("t4_add_done",  32'(done),      32'd0);
      check("t4_add_cnt",   32'(count),     32'd0);
      check("t4_add_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      check("t4_err_pulse", 32'(err), 32'd0);

      // 5: PUSH 7, DUP, NOT, AND -> 0
      do_reset();
      send(PUSH, 8'd7);
      send(DUP, 8'd0);
      check("t5_dup_cnt", 32'(count), 32'd2);
      check("t5_dup_tos", 32'(tos),   32'd7);
      send(NOT, 8'd0);
      check("t5_not_tos", 32'(tos),   32'hF8);
      check("t5_not_cnt", 32'(count), 32'd2);
      send(AND, 8'd0);
      @(posedge clk); #1;
      check("t5_and_tos",  32'(tos),   32'd0);
      check("t5_and_zero", 32'(zero),  32'd1);
      check("t5_and_cnt",  32'(count), 32'd1);
      send(NOP, 8'd0);
      check("t5_nop_done", 32'(done), 32'd1);
      check("t5_nop_cnt",  32'(count), 32'd1);

      // 6: asynchronous reset during EXEC
      do_reset();
      send(PUSH, 8'd1);
      send(PUSH, 8'd2);
      send(ADD, 8'd0);
      check("t6_in_exec", 32'(cmd_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("t6_cnt",   32'(count),     32'd0);
      check("t6_ready", 32'(cmd_ready), 32'd1);
      check("t6_done",  32'(done),      32'd0);
      check("t6_tos",   32'(tos),       32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("t6_no_done", 32'(done),  32'd0);
      check("t6_cnt_hold", 32'(count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
